// File: rtl/song_recorder_pkg.sv
// ============================================================================
// Module  : song_recorder_pkg
// Purpose : Shared song constants: map sizes, recorder state encoding, lanes.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package song_recorder_pkg;

    localparam int NUM_BEATS_DEF = 100;
    localparam int LEAD_IN_DEF   = 10;
    localparam int COUNT_W_DEF   = 8;

    typedef logic [1:0] state_t;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LEAD_IN = 2'd1;
    localparam logic [1:0] ST_RECORD  = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam int RED       = 0;
    localparam int YELLOW    = 1;
    localparam int BLUE      = 2;
    localparam int NUM_LANES = 3;

    function automatic logic [1:0] lane_count(input logic [NUM_LANES-1:0] lanes);
        return {1'b0, lanes[RED]} + {1'b0, lanes[YELLOW]} + {1'b0, lanes[BLUE]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/song_recorder_if.sv
// ============================================================================
// Module  : song_recorder_if
// Purpose : Control, key and note-map bundle between the recorder and its users.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface song_recorder_if #(
    parameter int NUM_BEATS = song_recorder_pkg::NUM_BEATS_DEF,
    parameter int COUNT_W   = song_recorder_pkg::COUNT_W_DEF
);
    logic                 start;
    logic                 stop;
    logic                 beat_tick;
    logic                 key_red;
    logic                 key_blue;
    logic                 key_yellow;
    logic [NUM_BEATS-1:0] output_red;
    logic [NUM_BEATS-1:0] output_blue;
    logic [NUM_BEATS-1:0] output_yellow;
    logic [COUNT_W-1:0]   output_total_notes;
    logic                 busy;
    logic                 done;

    modport master (
        output start, stop, beat_tick, key_red, key_blue, key_yellow,
        input  output_red, output_blue, output_yellow, output_total_notes, busy, done
    );

    modport slave (
        input  start, stop, beat_tick, key_red, key_blue, key_yellow,
        output output_red, output_blue, output_yellow, output_total_notes, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/song_recorder_key_edge_latch.sv
// ============================================================================
// Module  : key_edge_latch
// Purpose : Per-lane key rising-edge detector with a clearable note latch.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module key_edge_latch (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic key,
    input  wire logic arm,
    input  wire logic clear,
    output logic      hit
);
    logic key_prev;
    logic latched;
    logic rise;

    assign rise = key & ~key_prev;
    // A press landing in the same cycle as the beat tick still belongs to that beat.
    assign hit  = latched | (arm & rise);

    always_ff @(posedge clock) begin
        if (reset) begin
            key_prev <= 1'b0;
            latched  <= 1'b0;
        end else begin
            key_prev <= key;
            if (clear) begin
                latched <= 1'b0;
            end else if (arm && rise) begin
                latched <= 1'b1;
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/song_recorder.sv
// ============================================================================
// Module  : song_recorder
// Purpose : Records red/blue/yellow key presses into loader-format note maps.
//           SONG_RECORDER_SINGLE_LANE_EN limits each beat to one lane.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module song_recorder
    import song_recorder_pkg::*;
#(
    parameter int NUM_BEATS = NUM_BEATS_DEF,
    parameter int LEAD_IN   = LEAD_IN_DEF,
    parameter int COUNT_W   = COUNT_W_DEF
) (
    input  wire logic      clock,
    input  wire logic      reset,
    song_recorder_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_BEATS + 1);

    state_t               state;
    logic [IDX_W-1:0]     beat_idx;
    logic [NUM_BEATS-1:0] red_map;
    logic [NUM_BEATS-1:0] blue_map;
    logic [NUM_BEATS-1:0] yellow_map;
    logic [COUNT_W-1:0]   total;

    logic                 in_record;
    logic                 latch_clear;
    logic [NUM_LANES-1:0] keys;
    logic [NUM_LANES-1:0] hits;
    logic [NUM_LANES-1:0] lanes;
    logic [COUNT_W:0]     sum;
    logic [COUNT_W-1:0]   total_next;
    logic [IDX_W-1:0]     slot;
    logic                 last_beat;
    logic                 last_lead;

    assign in_record   = (state == ST_RECORD);
    assign latch_clear = ~in_record | bus.beat_tick | bus.stop;

    assign keys[RED]    = bus.key_red;
    assign keys[YELLOW] = bus.key_yellow;
    assign keys[BLUE]   = bus.key_blue;

    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
            key_edge_latch u_latch (
                .clock (clock),
                .reset (reset),
                .key   (keys[g]),
                .arm   (in_record),
                .clear (latch_clear),
                .hit   (hits[g])
            );
        end
    endgenerate

`ifdef SONG_RECORDER_SINGLE_LANE_EN
    always_comb begin
        lanes = '0;
        if (hits[RED]) begin
            lanes[RED] = 1'b1;
        end else if (hits[YELLOW]) begin
            lanes[YELLOW] = 1'b1;
        end else if (hits[BLUE]) begin
            lanes[BLUE] = 1'b1;
        end
    end
`else
    always_comb begin
        lanes = hits;
    end
`endif

    assign sum        = {1'b0, total} + (COUNT_W+1)'(lane_count(lanes));
    assign total_next = sum[COUNT_W] ? {COUNT_W{1'b1}} : sum[COUNT_W-1:0];

    // Beat 0 lives in the MSB so the map matches the song loader layout.
    assign slot      = IDX_W'(NUM_BEATS - 1) - beat_idx;
    assign last_beat = (beat_idx == IDX_W'(NUM_BEATS - 1));
    assign last_lead = (beat_idx == IDX_W'(LEAD_IN - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            beat_idx   <= '0;
            red_map    <= '0;
            blue_map   <= '0;
            yellow_map <= '0;
            total      <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state      <= ST_LEAD_IN;
                        beat_idx   <= '0;
                        red_map    <= '0;
                        blue_map   <= '0;
                        yellow_map <= '0;
                        total      <= '0;
                    end
                end
                ST_LEAD_IN: begin
                    if (bus.stop) begin
                        state <= ST_DONE;
                    end else if (bus.beat_tick) begin
                        beat_idx <= beat_idx + IDX_W'(1);
                        if (last_lead) begin
                            state <= ST_RECORD;
                        end
                    end
                end
                ST_RECORD: begin
                    if (bus.beat_tick) begin
                        red_map[slot]    <= lanes[RED];
                        yellow_map[slot] <= lanes[YELLOW];
                        blue_map[slot]   <= lanes[BLUE];
                        total            <= total_next;
                        beat_idx         <= beat_idx + IDX_W'(1);
                        if (last_beat || bus.stop) begin
                            state <= ST_DONE;
                        end
                    end else if (bus.stop) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.output_red         = red_map;
    assign bus.output_blue        = blue_map;
    assign bus.output_yellow      = yellow_map;
    assign bus.output_total_notes = total;
    assign bus.busy               = (state == ST_LEAD_IN) || (state == ST_RECORD);
    assign bus.done               = (state == ST_DONE);
endmodule

`default_nettype wire

// File: tb/tb_song_recorder.sv
// ============================================================================
// Module  : tb_song_recorder
// Purpose : Directed self-checking bench for song_recorder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_song_recorder;
    import song_recorder_pkg::*;

    localparam int NB = NUM_BEATS_DEF;
    localparam int CW = COUNT_W_DEF;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;
    logic [127:0] one;

    song_recorder_if #(.NUM_BEATS(NB), .COUNT_W(CW)) bus ();

    song_recorder #(.NUM_BEATS(NB), .LEAD_IN(LEAD_IN_DEF), .COUNT_W(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle's pulses, let the edge happen, then release them.
    task automatic step(input logic st, input logic sp, input logic bt);
        bus.start     = st;
        bus.stop      = sp;
        bus.beat_tick = bt;
        @(posedge clock);
        #1;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.beat_tick = 1'b0;
    endtask

    task automatic tick();
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_keys(input logic r, input logic y, input logic b);
        bus.key_red    = r;
        bus.key_yellow = y;
        bus.key_blue   = b;
    endtask

    task automatic run_to_done(input string tag);
        for (int i = 0; i < 200 && !bus.done; i++) tick();
        check_val(tag, {127'd0, bus.done}, 128'd1);
    endtask

    task automatic check_maps(input string tag, input logic [127:0] r,
                              input logic [127:0] y, input logic [127:0] b,
                              input logic [127:0] cnt);
        check_val({tag, "_red"},    {28'd0, bus.output_red},    r);
        check_val({tag, "_yellow"}, {28'd0, bus.output_yellow}, y);
        check_val({tag, "_blue"},   {28'd0, bus.output_blue},   b);
        check_val({tag, "_count"},  {120'd0, bus.output_total_notes}, cnt);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        one      = 128'd1;
        reset    = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.beat_tick = 1'b0;
        set_keys(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        check_val("rst_busy", {127'd0, bus.busy}, 128'd0);
        check_val("rst_done", {127'd0, bus.done}, 128'd0);
        check_maps("rst", 0, 0, 0, 0);

        // Empty recording: busy through tick 99, done after it.
        step(1'b1, 1'b0, 1'b0);
        check_val("empty_busy0", {127'd0, bus.busy}, 128'd1);
        ticks(99);
        check_val("empty_busy99", {127'd0, bus.busy}, 128'd1);
        tick();
        check_val("empty_busy_end", {127'd0, bus.busy}, 128'd0);
        check_val("empty_done", {127'd0, bus.done}, 128'd1);
        check_maps("empty", 0, 0, 0, 0);

        // Single red tap at beat 10, blue held from beat 20 to 25.
        step(1'b1, 1'b0, 1'b0);
        ticks(10);
        set_keys(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
        set_keys(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
        tick();
        ticks(9);
        set_keys(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b0);
        ticks(6);
        set_keys(1'b0, 1'b0, 1'b0);
        run_to_done("tap_done");
        check_maps("tap", one << 89, 0, one << 79, 2);

        // Red+yellow rising in the same cycle as the beat-30 tick.
        step(1'b1, 1'b0, 1'b0);
        ticks(30);
        set_keys(1'b1, 1'b1, 1'b0);
        tick();
        set_keys(1'b0, 1'b0, 1'b0);
        run_to_done("chord_done");
`ifdef SONG_RECORDER_SINGLE_LANE_EN
        check_maps("chord", one << 69, 0, 0, 1);
`else
        check_maps("chord", one << 69, one << 69, 0, 2);
`endif

        // Presses during lead-in, and a key held across RECORD entry.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            set_keys(1'b1, 1'b1, 1'b1); step(1'b0, 1'b0, 1'b0);
            set_keys(1'b0, 1'b0, 1'b0); tick();
        end
        set_keys(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        set_keys(1'b0, 1'b0, 1'b0);
        run_to_done("lead_done");
        check_maps("lead", 0, 0, 0, 0);

        // Stop together with the beat-50 tick while yellow is latched.
        step(1'b1, 1'b0, 1'b0);
        ticks(50);
        set_keys(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0);
        set_keys(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check_val("stop_done", {127'd0, bus.done}, 128'd1);
        check_val("stop_busy", {127'd0, bus.busy}, 128'd0);
        check_maps("stop", 0, one << 49, 0, 1);
        tick();
        check_maps("stop_hold", 0, one << 49, 0, 1);
        step(1'b1, 1'b0, 1'b0);
        check_val("restart_busy", {127'd0, bus.busy}, 128'd1);
        check_maps("restart", 0, 0, 0, 0);

        // A start pulse during lead-in must not rewind the beat index.
        ticks(5);
        step(1'b1, 1'b0, 1'b0);
        ticks(5);
        set_keys(1'b1, 1'b0, 1'b0);
        tick();
        set_keys(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check_val("ignore_start_done", {127'd0, bus.done}, 128'd1);
        check_maps("ignore_start", one << 89, 0, 0, 1);

        // Every key on every recorded beat: 270 notes saturate the count.
        step(1'b1, 1'b0, 1'b0);
        ticks(10);
        for (int i = 0; i < 90; i++) begin
            set_keys(1'b1, 1'b1, 1'b1); tick();
            set_keys(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
        end
        check_val("sat_done", {127'd0, bus.done}, 128'd1);
`ifdef SONG_RECORDER_SINGLE_LANE_EN
        check_maps("sat", (one << 90) - 1, 0, 0, 90);
`else
        check_maps("sat", (one << 90) - 1, (one << 90) - 1, (one << 90) - 1, 255);
`endif

        // Reset in the middle of a recording.
        step(1'b1, 1'b0, 1'b0);
        ticks(10);
        set_keys(1'b1, 1'b0, 1'b1); tick();
        set_keys(1'b0, 1'b0, 1'b0);
        ticks(3);
        check_val("mid_busy", {127'd0, bus.busy}, 128'd1);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        check_val("mid_rst_busy", {127'd0, bus.busy}, 128'd0);
        check_val("mid_rst_done", {127'd0, bus.done}, 128'd0);
        check_maps("mid_rst", 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
